banked_ram_stream_reader: RTL

Read initiator for the banked scratchpad RAM. It drives one read port (req/addr in, data back one cycle later). It issues a strided sequence of reads programmed by a start command and returns the words as a valid/ready stream with full backpressure. It sits between the banked RAM and downstream compute or store engines, and replaces ad-hoc address counters in those engines.

---
 rtl/banked_ram_pkg.sv | 30 +++
 rtl/banked_ram_stream_reader_fifo.sv | 62 ++++++
 rtl/banked_ram_stream_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/banked_ram_pkg.sv
// rtl/banked_ram_pkg.sv - shared types and helpers for the banked RAM stream reader
// Provides the FSM state encoding, a constant clog2 helper and the
// FIFO depth legality test used at elaboration time.
package banked_ram_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_DRAIN = DRAIN
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Depth must be a power of two so the FIFO pointers wrap naturally.
    function automatic bit fifo_depth_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/banked_ram_stream_reader_fifo.sv
// rtl/banked_ram_stream_reader_fifo.sv - register-based synchronous stream FIFO
// Ports: clk, reset (sync, active-low), push/push_data write side,
// pop/head_data read side (first-word fall-through), empty, full, count.
// The caller guarantees push never lands on a full FIFO unless it also pops.
module sync_stream_fifo
    import banked_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_data,
    output logic                    empty,
    output logic                    full,
    output logic [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_pop;

    assign do_pop    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/banked_ram_stream_reader.sv
// rtl/banked_ram_stream_reader.sv - strided RAM read initiator with valid/ready output
// Ports: clk, reset (sync, active-low); cfg_start/cfg_base_addr/cfg_stride/
// cfg_num_words command; busy/done status; mem_read_req/mem_read_addr/
// mem_read_data RAM port (data one cycle after req); m_valid/m_data/m_ready
// output stream.
module banked_ram_stream_reader
    import banked_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int COUNT_W    = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]   cfg_stride,
    input  logic [COUNT_W-1:0]      cfg_num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_read_req,
    output logic [ADDR_WIDTH-1:0]   mem_read_addr,
    input  logic [DATA_WIDTH-1:0]   mem_read_data,
    output logic                    m_valid,
    output logic [DATA_WIDTH-1:0]   m_data,
    input  logic                    m_ready
);

    localparam int FCNT_W = clog2(FIFO_DEPTH) + 1;

    if (!fifo_depth_legal(FIFO_DEPTH)) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be a power of two and at least 2");
    end

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  stride_q;
    logic [COUNT_W-1:0]     num_q;
    logic [COUNT_W-1:0]     issue_count;
    logic [COUNT_W-1:0]     accept_count;
    logic                   inflight;
    logic                   done_q;
    logic                   done_next;
    logic [FCNT_W-1:0]      fifo_count;
    logic [FCNT_W-1:0]      credit_used;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   last_issue;
    logic                   last_accept;

    // Credit counts the buffered words plus the one read that may still be
    // returning; both are registers, so m_ready never reaches mem_read_req.
    assign credit_used = fifo_count + FCNT_W'(inflight);
    assign pop         = m_valid && m_ready;
    assign last_issue  = (issue_count == num_q - COUNT_W'(1));
    assign last_accept = pop && (accept_count == num_q - COUNT_W'(1));

    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign mem_read_addr = addr_q;
    assign m_valid       = !fifo_empty;

    always_comb begin
        state_next   = state;
        mem_read_req = 1'b0;
        done_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (cfg_num_words != '0) begin
                        state_next = S_ISSUE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                mem_read_req = !fifo_full && (credit_used < FCNT_W'(FIFO_DEPTH));
                if (mem_read_req && last_issue) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_accept) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            stride_q     <= '0;
            num_q        <= '0;
            issue_count  <= '0;
            accept_count <= '0;
            inflight     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state    <= state_next;
            done_q   <= done_next;
            inflight <= mem_read_req;
            if (state == S_IDLE && cfg_start) begin
                addr_q       <= cfg_base_addr;
                stride_q     <= cfg_stride;
                num_q        <= cfg_num_words;
                issue_count  <= '0;
                accept_count <= '0;
            end else begin
                if (mem_read_req) begin
                    addr_q      <= addr_q + stride_q;
                    issue_count <= issue_count + COUNT_W'(1);
                end
                if (pop) begin
                    accept_count <= accept_count + COUNT_W'(1);
                end
            end
        end
    end

    // Returning data is pushed unconditionally; credit already reserved room.
    sync_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_read_data),
        .pop       (pop),
        .head_data (m_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

endmodule
